// File: rtl/mul_seq_ctrl_pkg.sv
// Shared ALU operation codes and multiply sequencer state encoding.
// Used by the ALU control decoder, the ALU and mul_seq_ctrl.
package mul_seq_ctrl_pkg;

  localparam logic [3:0] AND_OP = 4'd0;
  localparam logic [3:0] OR_OP  = 4'd1;
  localparam logic [3:0] ADD_OP = 4'd2;
  localparam logic [3:0] SLL_OP = 4'd3;
  localparam logic [3:0] SRL_OP = 4'd4;
  localparam logic [3:0] SUB_OP = 4'd6;
  localparam logic [3:0] SLT_OP = 4'd7;
  localparam logic [3:0] MUL_OP = 4'd8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: holds the multiplicand, multiplier and accumulator.
// Each step retires BITS_PER_CYCLE multiplier bits into the low DATA_W product bits.
module mul_shift_add_dp
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] acc
);

  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] partial;

  // mcand * low multiplier digit, built from shifted adds so no multiplier is inferred.
  always_comb begin
    partial = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      acc_d    = '0;
    end else if (step) begin
      acc_d    = acc_q + partial;
      mcand_d  = mcand_q << BITS_PER_CYCLE;
      mplier_d = mplier_q >> BITS_PER_CYCLE;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative multiply sequencer beside the EX-stage ALU: stalls the pipeline while a
// MUL runs through the shift-add datapath, then presents the product for one cycle.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              ex_valid,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid
);

  localparam int unsigned N_ITER = DATA_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ITER - 1);

  if (BITS_PER_CYCLE == 0 || (DATA_W % BITS_PER_CYCLE) != 0) begin : gen_param_check
    $error("mul_seq_ctrl: BITS_PER_CYCLE must be non-zero and divide DATA_W");
  end

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0] acc;
  logic              start;
  logic              load;
  logic              step;

  assign start = ex_valid & (alu_control == MUL_OP) & ~flush;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load         = 1'b0;
    step         = 1'b0;
    stall        = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          stall   = 1'b1;
          load    = 1'b1;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          stall = 1'b1;
          step  = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Always back to idle so the MUL still sitting in EX is not restarted.
        result_valid = ~flush;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A flushed product is never committed, so result keeps the last delivered value.
  assign result_d = result_valid ? acc : result_q;
  assign result   = result_d;
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  mul_shift_add_dp #(
    .DATA_W         (DATA_W),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_dp (
    .clk    (clk),
    .arst_n (arst_n),
    .load   (load),
    .step   (step),
    .op_a   (op_a),
    .op_b   (op_b),
    .acc    (acc)
  );

endmodule
